// File: rtl/intc_pkg.sv
// Shared types and defaults for the CPU-side interrupt entry/return sequencer.
package intc_pkg;

    localparam int unsigned ADDR_W_DEF      = 32;
    localparam int unsigned ISR_TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        ACK     = 3'd2,
        VECTOR  = 3'd3,
        SERVICE = 3'd4,
        RETURN  = 3'd5
    } irq_state_e;

endpackage

// File: rtl/isr_wdog_counter.sv
// Saturating service-cycle counter with a sticky overrun flag; ISR_TIMEOUT=0 disables it.
module isr_wdog_counter
    import intc_pkg::*;
#(
    parameter int unsigned ISR_TIMEOUT = ISR_TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic flag_o
);

    generate
        if (ISR_TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk_i, rst_i, clr_i, en_i};
            assign flag_o        = 1'b0;
        end else begin : g_on
            localparam int unsigned CW   = (ISR_TIMEOUT > 1) ? $clog2(ISR_TIMEOUT) : 1;
            localparam logic [CW-1:0] LAST = CW'(ISR_TIMEOUT - 1);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          flag_q, flag_d;

            // Count holds at LAST once reached; the flag never clears except on reset.
            always_comb begin
                cnt_d  = cnt_q;
                flag_d = flag_q;
                if (clr_i) begin
                    cnt_d = '0;
                end else if (en_i) begin
                    if (cnt_q == LAST) begin
                        flag_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q  <= '0;
                    flag_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    flag_q <= flag_d;
                end
            end

            assign flag_o = flag_q;
        end
    endgenerate

endmodule

// File: rtl/irq_sequencer.sv
// CPU interrupt entry sequencer: stall, single IACK, vector capture, PC redirect, ISR tracking, return.
module irq_sequencer
    import intc_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned ISR_TIMEOUT = ISR_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              irq,
    input  logic [ADDR_W-1:0] isr_addr,
    input  logic              int_en,
    input  logic              instr_boundary,
    input  logic [ADDR_W-1:0] cur_pc,
    input  logic              iret,
    output logic              iack,
    output logic              stall_req,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_val,
    output logic              in_isr,
    output logic [ADDR_W-1:0] epc,
    output logic              isr_timeout
);

    irq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] vec_q, vec_d;

    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        vec_d   = vec_q;
        unique case (state_q)
            IDLE: begin
                if (irq && int_en) state_d = REQ;
            end
            REQ: begin
                // A withdrawn request aborts; a dropped int_en does not.
                if (!irq) begin
                    state_d = IDLE;
                end else if (instr_boundary) begin
                    epc_d   = cur_pc;
                    state_d = ACK;
                end
            end
            ACK: begin
                vec_d   = isr_addr;
                state_d = VECTOR;
            end
            VECTOR:  state_d = SERVICE;
            SERVICE: begin
                if (iret) state_d = RETURN;
            end
            RETURN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            epc_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            vec_q   <= vec_d;
        end
    end

    always_comb begin
        iack        = 1'b0;
        stall_req   = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        in_isr      = 1'b0;
        unique case (state_q)
            REQ:    stall_req = 1'b1;
            ACK: begin
                stall_req = 1'b1;
                iack      = 1'b1;
            end
            VECTOR: begin
                stall_req   = 1'b1;
                pc_load     = 1'b1;
                pc_load_val = vec_q;
            end
            SERVICE: in_isr = 1'b1;
            RETURN: begin
                pc_load     = 1'b1;
                pc_load_val = epc_q;
            end
            default: ;
        endcase
    end

    assign epc = epc_q;

    isr_wdog_counter #(
        .ISR_TIMEOUT(ISR_TIMEOUT)
    ) u_wdog (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (state_q == RETURN),
        .en_i  (state_q == SERVICE),
        .flag_o(isr_timeout)
    );

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- CPU-side controller for the 4-line interrupt controller. It converts a pending IRQ into the CPU entry sequence: pipeline stall, a one-cycle IACK pulse, vector capture, PC redirect, ISR tracking and return.
- It is the only block allowed to drive the controller's IACK.
- One interrupt is in service at a time; there is no nesting.
- An ISR watchdog flags service routines that overrun.

Parameters:
- ADDR_W, 32, width of PC and vector addresses.
- ISR_TIMEOUT, 1024, number of SERVICE cycles before isr_timeout sets. 0 disables the watchdog.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- irq  input  1  pending-interrupt request from the interrupt controller.
- isr_addr  input  ADDR_W  vector of the highest-priority pending line; combinational from the interrupt controller.
- int_en  input  1  global interrupt enable (CSR).
- instr_boundary  input  1  CPU is at an instruction boundary; cur_pc is valid.
- cur_pc  input  ADDR_W  address of the next instruction to execute.
- iret  input  1  ISR-return instruction retired, single-cycle pulse.
- iack  output  1  interrupt acknowledge to the controller; exactly one cycle per accepted interrupt.
- stall_req  output  1  holds the CPU fetch/issue.
- pc_load  output  1  PC redirect strobe.
- pc_load_val  output  ADDR_W  redirect target.
- in_isr  output  1  high while an ISR executes.
- epc  output  ADDR_W  saved return address.
- isr_timeout  output  1  sticky watchdog flag.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high; it takes priority over every other input.
- Reset values:
  - State is IDLE.
  - iack, stall_req, pc_load, in_isr and isr_timeout are 0.
  - epc, pc_load_val and the vector register are 0.
  - The watchdog counter is 0.
- State register and decoding: all outputs are decoded from registered state and registers. There are no combinational input-to-output paths.
- IDLE: all strobes are 0. When irq & int_en is sampled high at an edge, go to REQ.
- REQ:
  - stall_req=1.
  - If irq is sampled low, return to IDLE with no IACK (withdrawn request, e.g. external reset of the controller).
  - Otherwise, if instr_boundary=1, capture epc<=cur_pc and go to ACK.
  - int_en falling while in REQ does not abort the sequence.
- ACK:
  - stall_req=1, iack=1 for exactly this cycle.
  - At the exiting edge, vector<=isr_addr. The same-cycle sample guarantees the captured vector matches the line IACK clears.
  - Go to VECTOR unconditionally.
- VECTOR: stall_req=1, pc_load=1, pc_load_val=vector. Go to SERVICE.
- SERVICE:
  - in_isr=1, stall_req=0.
  - The watchdog counts up from 0 on entry. When count==ISR_TIMEOUT-1, isr_timeout<=1. The flag is sticky until rst and does not abort the ISR. The counter saturates.
  - iret=1 goes to RETURN. irq is ignored while in SERVICE.
- RETURN: pc_load=1, pc_load_val=epc, in_isr=0. Go to IDLE and clear the watchdog count.
- iret outside SERVICE is ignored.
- Fixed latencies:
  - irq sampled at edge k with instr_boundary held high gives REQ at k, iack in the cycle after edge k+1, and pc_load in the cycle after edge k+2.
  - Entry latency is 3 cycles from the irq sample to pc_load.
- Back-to-back interrupts: a second irq still pending at RETURN is taken via IDLE→REQ, with at least 1 IDLE cycle between them (no tail-chaining).
- Reset mid-sequence (any state): go to IDLE next edge. No iack is issued after the reset edge, and an in-progress pc_load is dropped. A partially acknowledged interrupt stays pending in the controller.

Decomposition:
- Shared package intc_pkg holds:
  - the state enum: IDLE, REQ, ACK, VECTOR, SERVICE, RETURN (3-bit encoding);
  - ADDR_W default;
  - the ISR_TIMEOUT default.
- One sub-module, isr_wdog_counter: a saturating counter with clear/enable inputs and a sticky flag output, parameterised by ISR_TIMEOUT, with the zero-disables rule.

Test Plan:
1. Basic entry/return.
   - Stimulus: int_en=1, instr_boundary=1, cur_pc=0x0000_0100, isr_addr=0x0000_2000, irq rises.
   - Required response: iack is high for exactly 1 cycle, 2 cycles after the irq sample. pc_load=1 with 0x2000 on the next cycle, then in_isr=1. An iret pulse gives pc_load=1 with 0x0100.
2. Boundary wait.
   - Stimulus: irq high, instr_boundary held low for 5 cycles.
   - Required response: stall_req=1 for those 5 cycles, no iack. iack follows 1 cycle after instr_boundary rises, and epc equals cur_pc sampled at that edge.
3. Masked and withdrawn requests.
   - Stimulus A: int_en=0 with irq=1 for 20 cycles. Required response: stays IDLE, no stall_req.
   - Stimulus B: irq drops while in REQ. Required response: return to IDLE, iack never asserted.
4. Watchdog.
   - Stimulus: ISR_TIMEOUT=8, no iret for 10 SERVICE cycles.
   - Required response: isr_timeout sets after 8 SERVICE cycles and remains 1 after iret and through a second ISR. Only rst clears it.
5. Back-to-back interrupts.
   - Stimulus: irq still high at RETURN with isr_addr=0x3000.
   - Required response: exactly one IDLE cycle, then a new sequence with pc_load_val=0x3000. Exactly one iack per sequence.
6. Reset mid-ACK.
   - Stimulus: assert rst in the ACK cycle.
   - Required response: next cycle all outputs are 0 and state is IDLE. No pc_load occurs, and the sequence restarts only after rst deasserts.
